// File: rtl/mac_operand_feeder.sv
// Operand-pair FIFO feeding the MAC: one pair is popped onto the registered
// outputs on every rising edge of the MAC fetching-input flag.
module mac_operand_feeder #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  multiplicand_i,
    input  logic [WIDTH-1:0]  multiplier_i,
    input  logic              fetch_i,
    output logic [WIDTH-1:0]  multiplicand_o,
    output logic [WIDTH-1:0]  multiplier_o,
    output logic              consumed_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic              underrun_o
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic              fetch_q;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [WIDTH-1:0]  mem_a_q [DEPTH];
    logic [WIDTH-1:0]  mem_b_q [DEPTH];
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic              consumed_q, consumed_d;
    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;

    logic empty_s, full_s, pop_req_s, pop_s, underrun_ev_s, push_acc_s, drop_s;

    // All decisions use pre-edge state, so a pop frees a full slot for a same-edge push.
    assign empty_s       = (level_q == {(ADDR_W + 1){1'b0}});
    assign full_s        = (level_q == LVL_FULL);
    assign pop_req_s     = fetch_i & ~fetch_q;
    assign pop_s         = pop_req_s & ~empty_s;
    assign underrun_ev_s = pop_req_s & empty_s;
    assign push_acc_s    = push_i & (~full_s | pop_s);
    assign drop_s        = push_i & full_s & ~pop_s;

    // Next-state for pointers, level, presented operands and status flags.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        consumed_d = 1'b0;
        overflow_d = overflow_q;
        underrun_d = underrun_q;

        if (pop_s) begin
            mcand_d    = mem_a_q[rd_ptr_q];
            mplier_d   = mem_b_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            consumed_d = 1'b1;
        end else if (underrun_ev_s) begin
            mcand_d    = {WIDTH{1'b0}};
            mplier_d   = {WIDTH{1'b0}};
            underrun_d = 1'b1;
        end else begin
            mcand_d    = mcand_q;
            mplier_d   = mplier_q;
        end

        if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_acc_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Control and output state registers.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            fetch_q    <= 1'b0;
            rd_ptr_q   <= {ADDR_W{1'b0}};
            wr_ptr_q   <= {ADDR_W{1'b0}};
            level_q    <= {(ADDR_W + 1){1'b0}};
            mcand_q    <= {WIDTH{1'b0}};
            mplier_q   <= {WIDTH{1'b0}};
            consumed_q <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            fetch_q    <= fetch_i;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            consumed_q <= consumed_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    // FIFO storage; cleared on reset so no unknowns ever reach the MAC.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= {WIDTH{1'b0}};
                mem_b_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_acc_s) begin
            mem_a_q[wr_ptr_q] <= multiplicand_i;
            mem_b_q[wr_ptr_q] <= multiplier_i;
        end
    end

    assign multiplicand_o = mcand_q;
    assign multiplier_o   = mplier_q;
    assign consumed_o     = consumed_q;
    assign level_o        = level_q;
    assign empty_o        = empty_s;
    assign full_o         = full_s;
    assign overflow_o     = overflow_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_mac_operand_feeder;

    localparam int WIDTH  = 5;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic             clk_i = 1'b0;
    logic             nreset_i = 1'b0;
    logic             push_i = 1'b0;
    logic [WIDTH-1:0] multiplicand_i = '0;
    logic [WIDTH-1:0] multiplier_i = '0;
    logic             fetch_i = 1'b0;
    logic [WIDTH-1:0] multiplicand_o;
    logic [WIDTH-1:0] multiplier_o;
    logic             consumed_o;
    logic             empty_o;
    logic             full_o;
    logic [ADDR_W:0]  level_o;
    logic             overflow_o;
    logic             underrun_o;

    int vectors = 0;
    int errors  = 0;

    mac_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .nreset_i(nreset_i), .push_i(push_i),
        .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
        .fetch_i(fetch_i), .multiplicand_o(multiplicand_o),
        .multiplier_o(multiplier_o), .consumed_o(consumed_o),
        .empty_o(empty_o), .full_o(full_o), .level_o(level_o),
        .overflow_o(overflow_o), .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a queue of pairs plus the visible output state.
    logic [2*WIDTH-1:0] mq [$];
    logic [WIDTH-1:0]   m_a, m_b;
    logic               m_cons, m_ovf, m_und, m_prev;

    logic [17:0] dut_vec;
    assign dut_vec = {multiplicand_o, multiplier_o, consumed_o, empty_o, full_o,
                      level_o, overflow_o, underrun_o};

    function automatic logic [17:0] exp_vec();
        return {m_a, m_b, m_cons, mq.size() == 0, mq.size() == DEPTH,
                3'(mq.size()), m_ovf, m_und};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_a = '0; m_b = '0; m_cons = 1'b0; m_ovf = 1'b0; m_und = 1'b0; m_prev = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic f);
        int  pre;
        bit  popped;
        pre    = mq.size();
        popped = 1'b0;
        m_cons = 1'b0;
        if (f && !m_prev) begin
            if (pre > 0) begin
                {m_a, m_b} = mq.pop_front();
                m_cons = 1'b1;
                popped = 1'b1;
            end else begin
                m_a = '0; m_b = '0; m_und = 1'b1;
            end
        end
        m_prev = f;
        if (p) begin
            if (pre < DEPTH || popped) mq.push_back({a, b});
            else m_ovf = 1'b1;
        end
    endtask

    // Drive one cycle of inputs at the falling edge; model the rising edge.
    task automatic cycle(input logic p, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic f);
        @(negedge clk_i);
        push_i = p; multiplicand_i = a; multiplier_i = b; fetch_i = f;
        @(posedge clk_i);
        model_edge(p, a, b, f);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        nreset_i = 1'b0; push_i = 1'b0; fetch_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        nreset_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b1, 5'd11, 5'd12, 1'b0);
        cycle(1'b1, 5'd13, 5'd14, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1);
        #2 nreset_i = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_vec !== {5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_stream: got %h want %h", dut_vec,
                     {5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        end
        // Releasing reset with fetch already high must count as a rising edge.
        @(negedge clk_i);
        fetch_i = 1'b1; push_i = 1'b0;
        @(negedge clk_i);
        nreset_i = 1'b1;
        @(posedge clk_i);
        model_edge(1'b0, 5'd0, 5'd0, 1'b1);
        #1;
        vectors++;
        if (underrun_o !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_fetch_high: got %h want %h", dut_vec, exp_vec());
        end
        do_reset();
    endtask

    task automatic test_basic_fetch();
        cycle(1'b1, 5'd3, 5'd7, 1'b0);
        cycle(1'b1, 5'd5, 5'd2, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1);
        vectors++;
        if (multiplicand_o !== 5'd3 || multiplier_o !== 5'd7 || consumed_o !== 1'b1 ||
            dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL first_pop: got %h want %h", dut_vec, exp_vec());
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 5'd0, 5'd0, 1'b1);
            vectors++;
            if (consumed_o !== 1'b0 || multiplicand_o !== 5'd3 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL fetch_held_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1);
        vectors++;
        if (multiplicand_o !== 5'd5 || multiplier_o !== 5'd2 || empty_o !== 1'b1 ||
            dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL second_pop: got %h want %h", dut_vec, exp_vec());
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] v;
        for (int i = 1; i <= 4; i++) begin
            v = WIDTH'(i);
            cycle(1'b1, v, v, 1'b0);
        end
        cycle(1'b1, 5'd9, 5'd9, 1'b0);
        vectors++;
        if (full_o !== 1'b1 || level_o !== 3'd4 || overflow_o !== 1'b1 ||
            dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL overflow_drop: got %h want %h", dut_vec, exp_vec());
        end
        for (int i = 1; i <= 4; i++) begin
            v = WIDTH'(i);
            cycle(1'b0, 5'd0, 5'd0, 1'b1);
            vectors++;
            if (multiplicand_o !== v || multiplier_o !== v || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_order_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            cycle(1'b0, 5'd0, 5'd0, 1'b0);
        end
    endtask

    task automatic test_underrun();
        cycle(1'b0, 5'd0, 5'd0, 1'b1);
        vectors++;
        if (multiplicand_o !== 5'd0 || multiplier_o !== 5'd0 || underrun_o !== 1'b1 ||
            consumed_o !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL underrun: got %h want %h", dut_vec, exp_vec());
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] v;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            v = WIDTH'(i);
            cycle(1'b1, v, v, 1'b0);
        end
        cycle(1'b1, 5'd6, 5'd6, 1'b1);
        vectors++;
        if (multiplicand_o !== 5'd1 || level_o !== 3'd4 || overflow_o !== 1'b0 ||
            dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL full_push_pop: got %h want %h", dut_vec, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            v = (i == 3) ? 5'd6 : WIDTH'(i + 2);
            cycle(1'b0, 5'd0, 5'd0, 1'b0);
            cycle(1'b0, 5'd0, 5'd0, 1'b1);
            vectors++;
            if (multiplicand_o !== v || multiplier_o !== v || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_empty_push_pop();
        cycle(1'b0, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 5'd7, 5'd3, 1'b1);
        vectors++;
        if (multiplicand_o !== 5'd0 || underrun_o !== 1'b1 || level_o !== 3'd1 ||
            dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL empty_push_pop: got %h want %h", dut_vec, exp_vec());
        end
        cycle(1'b0, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 5'd0, 1'b1);
        vectors++;
        if (multiplicand_o !== 5'd7 || multiplier_o !== 5'd3 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL empty_push_then_pop: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic p, f;
        logic [WIDTH-1:0] a, b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 55);
            f = ($urandom_range(0, 99) < 45);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cycle(p, a, b, f);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 200) do_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_fetch();
        test_overflow();
        test_underrun();
        test_full_push_pop();
        test_empty_push_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
